wb_demux: RTL and testbench

//  Parametrised, registered 1-to-NUM_CH write-back demultiplexer with valid/ready handshake.

---
 rtl/wb_demux_pkg.sv | 9 +
 rtl/wb_demux_if.sv | 35 +++
 rtl/wb_demux_slot.sv | 33 +++
 rtl/wb_demux.sv | 50 +++++
 tb/tb_wb_demux.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_demux_pkg.sv
// wb_demux_pkg: shared defaults, select-width helper and word type for the write-back demux
package wb_demux_pkg;
  localparam int WB_NUM_CH = 16;
  localparam int WB_DW = 32;
  typedef logic [WB_DW-1:0] wb_word_t;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wb_demux_if.sv
// wb_demux_if: write-back demux bus bundle
//   source side : in_valid, in_ready, in_sel, in_data (and in_bcast with WB_DEMUX_BCAST_EN)
//   sink side   : out_valid[NUM_CH], out_ready[NUM_CH], out_data[NUM_CH*DW], sel_err
//   master = environment view, slave = demux view
interface wb_demux_if import wb_demux_pkg::*; #(
  parameter int NUM_CH = WB_NUM_CH,
  parameter int DW = WB_DW
);
  localparam int SEL_W = sel_w(NUM_CH);
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [DW-1:0] in_data;
`ifdef WB_DEMUX_BCAST_EN
  logic in_bcast;
`endif
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [NUM_CH*DW-1:0] out_data;
  logic sel_err;
  modport master (
`ifdef WB_DEMUX_BCAST_EN
    output in_bcast,
`endif
    output in_valid, in_sel, in_data, out_ready,
    input in_ready, out_valid, out_data, sel_err
  );
  modport slave (
`ifdef WB_DEMUX_BCAST_EN
    input in_bcast,
`endif
    input in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );
endinterface

// File: rtl/wb_demux_slot.sv
// wb_demux_slot: one-entry output register for a single demux channel
//   clk, rst_n : clock, async active-low reset
//   load       : write data_in this edge (only issued while free)
//   data_in    : incoming word
//   ready      : sink ready
//   valid      : entry holds a word
//   data_out   : held word, keeps its last value after draining
//   free       : entry can take a word this cycle (empty or draining)
module wb_demux_slot import wb_demux_pkg::*; #(
  parameter int DW = WB_DW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [DW-1:0] data_in,
  input  logic ready,
  output logic valid,
  output logic [DW-1:0] data_out,
  output logic free
);
  assign free = !valid | ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data_out <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data_out <= data_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_demux.sv
// wb_demux: registered 1-to-NUM_CH write-back demux with per-channel back-pressure
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_demux_if.slave (source handshake, per-channel outputs, sel_err pulse)
//   WB_DEMUX_BCAST_EN : adds bus.in_bcast, an all-or-nothing load of every channel
module wb_demux import wb_demux_pkg::*; #(
  parameter int NUM_CH = WB_NUM_CH,
  parameter int DW = WB_DW
) (
  input logic clk,
  input logic rst_n,
  wb_demux_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_CH);
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load;
  logic [2**SEL_W-1:0] free_ext;
  logic in_range;
  logic bcast;
  logic accept;
`ifdef WB_DEMUX_BCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif
  assign in_range = {1'b0, bus.in_sel} < (SEL_W+1)'(NUM_CH);
  // Unused select codes read as free so out-of-range words are sunk.
  always_comb begin
    free_ext = '1;
    free_ext[NUM_CH-1:0] = free;
  end
  assign bus.in_ready = bcast ? &free : free_ext[bus.in_sel];
  assign accept = bus.in_valid & bus.in_ready;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    assign load[i] = accept & (bcast | (bus.in_sel == SEL_W'(i)));
    wb_demux_slot #(.DW(DW)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[i]),
      .data_in(bus.in_data),
      .ready(bus.out_ready[i]),
      .valid(bus.out_valid[i]),
      .data_out(bus.out_data[i*DW +: DW]),
      .free(free[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.sel_err <= 1'b0;
    else bus.sel_err <= accept & !bcast & !in_range;
  end
endmodule

// File: tb/tb_wb_demux.sv
// tb_wb_demux: directed self-checking bench for wb_demux (16-channel and 12-channel instances)
module tb_wb_demux;
  logic clk;
  logic rst_n;
  int n_cmp;
  int n_err;

  wb_demux_if #(.NUM_CH(16), .DW(32)) bus16 ();
  wb_demux_if #(.NUM_CH(12), .DW(32)) bus12 ();

  wb_demux #(.NUM_CH(16), .DW(32)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  wb_demux #(.NUM_CH(12), .DW(32)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input logic [31:0] d);
    bus16.in_valid = 1'b1;
    bus16.in_sel = s;
    bus16.in_data = d;
    tick();
    bus16.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus16.out_ready = 16'h0000;
    send(4'd2, 32'h0000_0022);
    send(4'd5, 32'h0000_0055);
    n_cmp++;
    if (bus16.out_valid !== 16'h0024) begin
      n_err++;
      $display("FAIL reset_preload: out_valid got %h want 0024", bus16.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus16.out_valid !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_valid: got %h want 0000", bus16.out_valid);
    end
    n_cmp++;
    if (bus16.out_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", bus16.out_data);
    end
    n_cmp++;
    if (bus16.sel_err !== 1'b0 || bus12.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sel_err: got %b/%b want 0/0", bus16.sel_err, bus12.sel_err);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_unicast();
    bus16.out_ready = 16'hFFFF;
    bus16.in_valid = 1'b1;
    bus16.in_sel = 4'd5;
    bus16.in_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (bus16.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL uni_in_ready: got %b want 1", bus16.in_ready);
    end
    tick();
    bus16.in_valid = 1'b0;
    n_cmp++;
    if (bus16.out_valid !== 16'h0020) begin
      n_err++;
      $display("FAIL uni_valid: got %h want 0020", bus16.out_valid);
    end
    n_cmp++;
    if (bus16.out_data[5*32 +: 32] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL uni_data: got %h want deadbeef", bus16.out_data[5*32 +: 32]);
    end
    tick();
    n_cmp++;
    if (bus16.out_valid !== 16'h0000) begin
      n_err++;
      $display("FAIL uni_drain: got %h want 0000", bus16.out_valid);
    end
    n_cmp++;
    if (bus16.out_data[5*32 +: 32] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL uni_hold: got %h want deadbeef", bus16.out_data[5*32 +: 32]);
    end
  endtask

  task automatic test_backpressure();
    bus16.out_ready = 16'hFFF7;
    send(4'd3, 32'h0000_0333);
    n_cmp++;
    if (bus16.out_valid !== 16'h0008) begin
      n_err++;
      $display("FAIL bp_load: out_valid got %h want 0008", bus16.out_valid);
    end
    bus16.in_valid = 1'b1;
    bus16.in_sel = 4'd3;
    bus16.in_data = 32'h0000_0BAD;
    #1;
    n_cmp++;
    if (bus16.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_in_ready_stall: got %b want 0", bus16.in_ready);
    end
    tick();
    n_cmp++;
    if (bus16.out_data[3*32 +: 32] !== 32'h0000_0333 || bus16.out_valid !== 16'h0008) begin
      n_err++;
      $display("FAIL bp_hold: data %h valid %h want 00000333/0008", bus16.out_data[3*32 +: 32], bus16.out_valid);
    end
    bus16.in_sel = 4'd4;
    bus16.in_data = 32'h0000_0444;
    #1;
    n_cmp++;
    if (bus16.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_in_ready_other: got %b want 1", bus16.in_ready);
    end
    tick();
    bus16.in_valid = 1'b0;
    n_cmp++;
    if (bus16.out_valid !== 16'h0018 || bus16.out_data[4*32 +: 32] !== 32'h0000_0444) begin
      n_err++;
      $display("FAIL bp_other_load: valid %h data %h want 0018/00000444", bus16.out_valid, bus16.out_data[4*32 +: 32]);
    end
    n_cmp++;
    if (bus16.out_data[3*32 +: 32] !== 32'h0000_0333) begin
      n_err++;
      $display("FAIL bp_ch3_kept: got %h want 00000333", bus16.out_data[3*32 +: 32]);
    end
    bus16.out_ready = 16'hFFFF;
    tick();
    n_cmp++;
    if (bus16.out_valid !== 16'h0000) begin
      n_err++;
      $display("FAIL bp_release: got %h want 0000", bus16.out_valid);
    end
  endtask

  task automatic test_throughput();
    bus16.out_ready = 16'hFFFF;
    bus16.in_valid = 1'b1;
    bus16.in_sel = 4'd7;
    for (int k = 1; k <= 4; k++) begin
      bus16.in_data = 32'(k);
      tick();
      n_cmp++;
      if (bus16.out_valid !== 16'h0080 || bus16.out_data[7*32 +: 32] !== 32'(k)) begin
        n_err++;
        $display("FAIL thru_%0d: valid %h data %h want 0080/%h", k, bus16.out_valid, bus16.out_data[7*32 +: 32], 32'(k));
      end
    end
    bus16.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus16.out_valid !== 16'h0000) begin
      n_err++;
      $display("FAIL thru_drain: got %h want 0000", bus16.out_valid);
    end
  endtask

  task automatic test_sel_err();
    bus12.out_ready = 12'h000;
    bus12.in_valid = 1'b1;
    bus12.in_sel = 4'd1;
    bus12.in_data = 32'h0000_0011;
    tick();
    n_cmp++;
    if (bus12.out_valid !== 12'h002 || bus12.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_inrange: valid %h sel_err %b want 002/0", bus12.out_valid, bus12.sel_err);
    end
    #1;
    n_cmp++;
    if (bus12.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL err_stalled_ready: got %b want 0", bus12.in_ready);
    end
    bus12.in_sel = 4'd13;
    bus12.in_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (bus12.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL err_in_ready: got %b want 1", bus12.in_ready);
    end
    tick();
    bus12.in_valid = 1'b0;
    n_cmp++;
    if (bus12.sel_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_pulse: got %b want 1", bus12.sel_err);
    end
    n_cmp++;
    if (bus12.out_valid !== 12'h002 || bus12.out_data[1*32 +: 32] !== 32'h0000_0011) begin
      n_err++;
      $display("FAIL err_no_change: valid %h data %h want 002/00000011", bus12.out_valid, bus12.out_data[1*32 +: 32]);
    end
    tick();
    n_cmp++;
    if (bus12.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_one_cycle: got %b want 0", bus12.sel_err);
    end
    bus12.out_ready = 12'hFFF;
    tick();
  endtask

`ifdef WB_DEMUX_BCAST_EN
  task automatic test_bcast();
    bus16.out_ready = 16'hFFFE;
    send(4'd0, 32'h0000_0001);
    bus16.in_bcast = 1'b1;
    bus16.in_valid = 1'b1;
    bus16.in_sel = 4'd3;
    bus16.in_data = 32'h5A5A_5A5A;
    #1;
    n_cmp++;
    if (bus16.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bc_stall_ready: got %b want 0", bus16.in_ready);
    end
    tick();
    n_cmp++;
    if (bus16.out_valid !== 16'h0001 || bus16.out_data[31:0] !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL bc_no_partial: valid %h data0 %h want 0001/00000001", bus16.out_valid, bus16.out_data[31:0]);
    end
    bus16.out_ready = 16'hFFFF;
    #1;
    n_cmp++;
    if (bus16.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bc_ready: got %b want 1", bus16.in_ready);
    end
    tick();
    bus16.in_valid = 1'b0;
    bus16.in_bcast = 1'b0;
    n_cmp++;
    if (bus16.out_valid !== 16'hFFFF || bus16.sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL bc_valid: valid %h sel_err %b want ffff/0", bus16.out_valid, bus16.sel_err);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (bus16.out_data[i*32 +: 32] !== 32'h5A5A_5A5A) begin
        n_err++;
        $display("FAIL bc_data_%0d: got %h want 5a5a5a5a", i, bus16.out_data[i*32 +: 32]);
      end
    end
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_sel = '0;
    bus16.in_data = '0;
    bus16.out_ready = '0;
    bus12.in_valid = 1'b0;
    bus12.in_sel = '0;
    bus12.in_data = '0;
    bus12.out_ready = '0;
`ifdef WB_DEMUX_BCAST_EN
    bus16.in_bcast = 1'b0;
    bus12.in_bcast = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    test_reset();
    test_unicast();
    test_backpressure();
    test_throughput();
    test_sel_err();
`ifdef WB_DEMUX_BCAST_EN
    test_bcast();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
